// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter and sequencer for a single-port memory with read timeout.
// Optional round-robin grant between requesters when MEM_ARB_RR_EN is defined.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_req_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_W-1:0]     ifu_resp_data,
  output logic                  ifu_resp_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_req_addr,
  input  logic                  lsu_req_wen,
  input  logic [DATA_W-1:0]     lsu_req_wdata,
  input  logic [DATA_W/8-1:0]   lsu_req_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_W-1:0]     lsu_resp_data,
  output logic                  lsu_resp_err,
  output logic                  mem_ren,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask
);

  localparam int unsigned CNT_W = 8;
  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  typedef enum logic [1:0] {IDLE, WAIT_RD, WR_ACK} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prefer_lsu;
  logic             grant_lsu, grant_ifu;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  // On contention, favour whichever requester did not win last time.
  assign prefer_lsu = (last_q == OWNER_IFU);
`else
  assign prefer_lsu = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWNER_IFU;
      cnt_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_q  <= OWNER_IFU;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Next state and combinational outputs; everything stays 0 while reset is held.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_data  = '0;
    ifu_resp_err   = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_resp_data  = '0;
    lsu_resp_err   = 1'b0;
    mem_ren        = 1'b0;
    mem_wen        = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    grant_lsu      = lsu_req_valid && (!ifu_req_valid || prefer_lsu);
    grant_ifu      = ifu_req_valid && !grant_lsu;
`ifdef MEM_ARB_RR_EN
    last_d         = last_q;
`endif

    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (grant_lsu) begin
            lsu_req_ready = 1'b1;
            mem_addr      = lsu_req_addr;
            mem_wdata     = lsu_req_wdata;
            mem_wmask     = lsu_req_wmask;
            owner_d       = OWNER_LSU;
            if (lsu_req_wen) begin
              mem_wen = 1'b1;
              state_d = WR_ACK;
            end else begin
              mem_ren = 1'b1;
              cnt_d   = CNT_W'(1);
              state_d = WAIT_RD;
            end
`ifdef MEM_ARB_RR_EN
            last_d = OWNER_LSU;
`endif
          end else if (grant_ifu) begin
            ifu_req_ready = 1'b1;
            mem_addr      = ifu_req_addr;
            mem_ren       = 1'b1;
            owner_d       = OWNER_IFU;
            cnt_d         = CNT_W'(1);
            state_d       = WAIT_RD;
`ifdef MEM_ARB_RR_EN
            last_d = OWNER_IFU;
`endif
          end
        end
        WAIT_RD: begin
          if (mem_rvalid) begin
            if (owner_q == OWNER_LSU) begin
              lsu_resp_valid = 1'b1;
              lsu_resp_data  = mem_rdata;
            end else begin
              ifu_resp_valid = 1'b1;
              ifu_resp_data  = mem_rdata;
            end
            state_d = IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            if (owner_q == OWNER_LSU) begin
              lsu_resp_valid = 1'b1;
              lsu_resp_err   = 1'b1;
            end else begin
              ifu_resp_valid = 1'b1;
              ifu_resp_err   = 1'b1;
            end
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WR_ACK: begin
          lsu_resp_valid = 1'b1;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected responses, a negedge monitor checks them.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              ifu_req_valid, ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_resp_data;
  logic              ifu_resp_err;
  logic              lsu_req_valid, lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_wen;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [MASK_W-1:0] lsu_req_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_resp_data;
  logic              lsu_resp_err;
  logic              mem_ren, mem_wen, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata, mem_wdata;
  logic [MASK_W-1:0] mem_wmask;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );

  typedef struct packed {
    logic              lsu;
    logic [DATA_W-1:0] data;
    logic              err;
    logic [31:0]       cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;
  logic [3:0]  pat;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic clr();
    ifu_req_valid = 0; ifu_req_addr = '0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0;
    lsu_req_wdata = '0; lsu_req_wmask = '0;
    mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic push(input logic l, input logic [DATA_W-1:0] d, input logic e, input int unsigned dly);
    exp_t x;
    x.lsu = l; x.data = d; x.err = e; x.cyc = 32'(cyc + dly);
    sb.push_back(x);
  endtask

  // Response monitor: every resp_valid must match the oldest expectation, on the expected cycle.
  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < 32'(cyc)) begin
      e = sb.pop_front();
      checks++;
      $display("FAIL resp_missing: got none expected lsu=%0b data=0x%0h err=%0b at cyc %0d",
               e.lsu, e.data, e.err, e.cyc);
    end
    if (ifu_resp_valid || lsu_resp_valid) begin
      checks++;
      if (ifu_resp_valid && lsu_resp_valid)
        $display("FAIL resp_both: got both resp_valid at cyc %0d expected one", cyc);
      else if (sb.size() == 0)
        $display("FAIL resp_unexpected: got lsu=%0b at cyc %0d expected none", lsu_resp_valid, cyc);
      else begin
        e = sb.pop_front();
        if (lsu_resp_valid == e.lsu && e.cyc == 32'(cyc) &&
            (lsu_resp_valid ? lsu_resp_data : ifu_resp_data) == e.data &&
            (lsu_resp_valid ? lsu_resp_err : ifu_resp_err) == e.err)
          passes++;
        else
          $display("FAIL resp: got lsu=%0b data=0x%0h err=%0b cyc=%0d expected lsu=%0b data=0x%0h err=%0b cyc=%0d",
                   lsu_resp_valid, lsu_resp_valid ? lsu_resp_data : ifu_resp_data,
                   lsu_resp_valid ? lsu_resp_err : ifu_resp_err, cyc, e.lsu, e.data, e.err, e.cyc);
      end
    end
    checks++;
    if ((!ifu_resp_valid && (ifu_resp_data != 0 || ifu_resp_err)) ||
        (!lsu_resp_valid && (lsu_resp_data != 0 || lsu_resp_err)))
      $display("FAIL resp_idle_zero: got ifu 0x%0h/%0b lsu 0x%0h/%0b expected 0 at cyc %0d",
               ifu_resp_data, ifu_resp_err, lsu_resp_data, lsu_resp_err, cyc);
    else passes++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef MEM_ARB_RR_EN
    pat = 4'b0101;
`else
    pat = 4'b1111;
`endif
    clr();
    reset = 1;
    ifu_req_valid = 1; lsu_req_valid = 1; lsu_req_addr = 32'h1234;
    nxt(); mid();
    chk("rst_ifu_ready", 64'(ifu_req_ready), 0);
    chk("rst_lsu_ready", 64'(lsu_req_ready), 0);
    chk("rst_mem_ren", 64'(mem_ren), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    nxt(); reset = 0; clr();
    nxt();

    // IFU read alone
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    mid();
    chk("t1_ifu_ready", 64'(ifu_req_ready), 1);
    chk("t1_lsu_ready", 64'(lsu_req_ready), 0);
    chk("t1_mem_ren", 64'(mem_ren), 1);
    chk("t1_mem_wen", 64'(mem_wen), 0);
    chk("t1_mem_addr", 64'(mem_addr), 64'h8000_0000);
    push(0, 64'h1122_3344_5566_7788, 0, 1);
    nxt(); ifu_req_valid = 0; mem_rvalid = 1; mem_rdata = 64'h1122_3344_5566_7788;
    mid();
    chk("t1_ren_c1", 64'(mem_ren), 0);
    nxt(); clr(); nxt();

    // IFU read and LSU write contend; LSU wins, IFU follows after the ack
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
    lsu_req_wdata = 64'hDEAD_BEEF; lsu_req_wmask = 8'h0F;
    mid();
    chk("t2_mem_wen", 64'(mem_wen), 1);
    chk("t2_mem_ren", 64'(mem_ren), 0);
    chk("t2_mem_wmask", 64'(mem_wmask), 64'h0F);
    chk("t2_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
    chk("t2_mem_addr", 64'(mem_addr), 64'h8000_1000);
    chk("t2_lsu_ready", 64'(lsu_req_ready), 1);
    chk("t2_ifu_ready", 64'(ifu_req_ready), 0);
    push(1, 64'h0, 0, 1);
    nxt(); lsu_req_valid = 0; lsu_req_wen = 0;
    mid();
    chk("t2_ifu_ready_c1", 64'(ifu_req_ready), 0);
    chk("t2_ren_c1", 64'(mem_ren), 0);
    nxt(); mid();
    chk("t2_ifu_ready_c2", 64'(ifu_req_ready), 1);
    chk("t2_ren_c2", 64'(mem_ren), 1);
    push(0, 64'h0BAD_F00D, 0, 1);
    nxt(); ifu_req_valid = 0; mem_rvalid = 1; mem_rdata = 64'h0BAD_F00D;
    nxt(); clr(); nxt();

    // LSU read with no memory answer: timeout error 16 cycles after issue
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000;
    mid();
    chk("t3_lsu_ready", 64'(lsu_req_ready), 1);
    chk("t3_mem_ren", 64'(mem_ren), 1);
    push(1, 64'h0, 1, 16);
    nxt(); lsu_req_valid = 0;
    for (int i = 1; i < 16; i++) nxt();
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_2008;
    mid();
    chk("t3_ready_timeout_cyc", 64'(lsu_req_ready), 0);
    nxt(); mid();
    chk("t3_ready_after", 64'(lsu_req_ready), 1);
    chk("t3_ren_after", 64'(mem_ren), 1);
    push(1, 64'hCAFE, 0, 1);
    nxt(); lsu_req_valid = 0; mem_rvalid = 1; mem_rdata = 64'hCAFE;
    nxt(); clr(); nxt();

    // IFU read answered exactly in the timeout cycle is a normal response
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0040;
    mid();
    chk("t3b_ren", 64'(mem_ren), 1);
    push(0, 64'hA5A5, 0, 16);
    nxt(); ifu_req_valid = 0;
    for (int i = 1; i < 16; i++) nxt();
    mem_rvalid = 1; mem_rdata = 64'hA5A5;
    nxt(); clr(); nxt();

    // Reset while waiting for a read drops the transaction
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_3000;
    mid();
    chk("t4_lsu_ready", 64'(lsu_req_ready), 1);
    nxt(); lsu_req_valid = 0; reset = 1; ifu_req_valid = 1;
    mid();
    chk("t4_rst_ifu_ready", 64'(ifu_req_ready), 0);
    chk("t4_rst_ren", 64'(mem_ren), 0);
    nxt(); reset = 0; ifu_req_valid = 0; mem_rvalid = 1; mem_rdata = 64'hBAD0;
    mid();
    chk("t4_stale_ren", 64'(mem_ren), 0);
    nxt(); mem_rvalid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_4000;
    mid();
    chk("t4_ifu_ready", 64'(ifu_req_ready), 1);
    chk("t4_ren", 64'(mem_ren), 1);
    chk("t4_addr", 64'(mem_addr), 64'h8000_4000);
    push(0, 64'h4444, 0, 1);
    nxt(); ifu_req_valid = 0; mem_rvalid = 1; mem_rdata = 64'h4444;
    nxt(); clr(); nxt();

    // Both held valid for four grants
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_5000;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_6000;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("t5_lsu_ready%0d", k), 64'(lsu_req_ready), 64'(pat[k]));
      chk($sformatf("t5_ifu_ready%0d", k), 64'(ifu_req_ready), 64'(!pat[k]));
      chk($sformatf("t5_addr%0d", k), 64'(mem_addr), pat[k] ? 64'h8000_6000 : 64'h8000_5000);
      push(pat[k], 64'h100 + 64'(k), 0, 1);
      nxt(); mem_rvalid = 1; mem_rdata = 64'h100 + 64'(k);
      mid();
      chk($sformatf("t5_wait_ready%0d", k), 64'(lsu_req_ready | ifu_req_ready), 0);
      nxt(); mem_rvalid = 0;
    end
    clr(); nxt();

    // Back-to-back IFU reads with a 1-cycle memory
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    mid();
    chk("t6_ren_c0", 64'(mem_ren), 1);
    push(0, 64'hAAAA_0000, 0, 1);
    nxt(); ifu_req_addr = 32'h8000_0008; mem_rvalid = 1; mem_rdata = 64'hAAAA_0000;
    mid();
    chk("t6_ren_c1", 64'(mem_ren), 0);
    chk("t6_ready_c1", 64'(ifu_req_ready), 0);
    nxt(); mem_rvalid = 0;
    mid();
    chk("t6_ren_c2", 64'(mem_ren), 1);
    chk("t6_addr_c2", 64'(mem_addr), 64'h8000_0008);
    push(0, 64'hBBBB_0008, 0, 1);
    nxt(); ifu_req_valid = 0; mem_rvalid = 1; mem_rdata = 64'hBBBB_0008;
    mid();
    chk("t6_ren_c3", 64'(mem_ren), 0);
    nxt(); clr();
    nxt(); nxt(); mid();
    chk("sb_drain", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port DPI-C backed memory model.
- Requesters: instruction fetch unit (IFU, read-only) and load/store unit (LSU, read/write).
- Issues one transaction at a time with single-cycle request pulses on the memory port and waits for the read response.
- Routes each response back to the owning requester, and returns an error response if the memory fails to answer within a bounded time.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 64, data width on all ports; mask width is DATA_W/8.
- TIMEOUT, 16, maximum cycles after issue to wait for mem_rvalid; legal range 2..255.

Ports:
- clock  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  ADDR_W  IFU read address.
- ifu_resp_valid  out  1  IFU response pulse, 1 cycle.
- ifu_resp_data  out  DATA_W  IFU read data.
- ifu_resp_err  out  1  IFU response is a timeout.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_req_addr  in  ADDR_W  LSU address.
- lsu_req_wen  in  1  1 = write, 0 = read.
- lsu_req_wdata  in  DATA_W  LSU write data.
- lsu_req_wmask  in  DATA_W/8  LSU byte write mask.
- lsu_resp_valid  out  1  LSU response pulse, 1 cycle.
- lsu_resp_data  out  DATA_W  LSU read data; 0 for writes.
- lsu_resp_err  out  1  LSU response is a timeout.
- mem_ren  out  1  memory read enable pulse.
- mem_addr  out  ADDR_W  memory address.
- mem_rdata  in  DATA_W  memory read data, valid with mem_rvalid.
- mem_rvalid  in  1  memory read data valid.
- mem_wen  out  1  memory write enable pulse; the write completes in the same cycle.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  DATA_W/8  memory byte mask.

Behaviour:
- State machine states: IDLE, WAIT_RD, WR_ACK. The block also holds an owner register (IFU or LSU) and an 8-bit timeout counter.
- Reset:
  - While reset is high, state goes to IDLE, the counter clears, and the grant history clears.
  - While reset is high, every output is 0, including ready, mem_ren and mem_wen.
  - Reset wins over any in-flight transaction. The dropped transaction produces no response.
- IDLE, grant:
  - Grant is combinational from the valid inputs.
  - The granted requester sees ready=1 in the same cycle. The other requester sees ready=0.
  - Default policy is fixed priority: LSU > IFU.
  - mem_addr, mem_wdata and mem_wmask are driven from the granted requester; they are 0 when nothing is granted.
- IDLE, granted read:
  - mem_ren=1 for this cycle only.
  - Owner is latched, counter set to 1, next state WAIT_RD.
- IDLE, granted LSU write:
  - mem_wen=1 for this cycle only, with mem_ren=0.
  - Owner is set to LSU, next state WR_ACK.
- mem_rvalid while in IDLE or WR_ACK is ignored. This covers stale responses after reset.
- WAIT_RD:
  - Both ready outputs are 0. mem_ren and mem_wen are 0.
  - If mem_rvalid=1: owner's resp_valid=1, resp_data=mem_rdata (combinational pass-through), resp_err=0; next state IDLE.
  - Else if counter==TIMEOUT: owner's resp_valid=1, resp_data=0, resp_err=1; next state IDLE.
  - Else the counter increments.
  - mem_rvalid arriving in the TIMEOUT cycle is a normal response, not an error.
- WR_ACK:
  - lsu_resp_valid=1, lsu_resp_data=0, lsu_resp_err=0; next state IDLE.
  - Both ready outputs are 0.
- Latency:
  - Read issued at cycle 0 with a 1-cycle memory: response at cycle 1; next grant possible at cycle 2.
  - Write issued at cycle 0: ack at cycle 1; next grant at cycle 2.
- Responses have no backpressure. The non-owner's resp_valid is always 0, and all resp_data/err are 0 when resp_valid is 0.
- A request that is not granted must be held by the requester. The arbiter does not latch the losing request.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - A 1-bit last_grant register, reset to IFU, updates on each accepted request.
  - When both requesters are valid in IDLE, the grant goes to the requester that was not granted last.
  - A single valid requester is always granted.
- Undefined:
  - No last_grant register; fixed LSU > IFU priority.

Test Plan:
- IFU read 0x80000000 alone, memory returns 0x1122334455667788 at cycle 1 -> ifu_req_ready=1 and mem_ren=1 at cycle 0 only; ifu_resp_valid=1, data=0x1122334455667788, err=0 at cycle 1; lsu_resp_valid stays 0.
- Cycle 0: IFU read 0x80000000 and LSU write 0x80001000, wdata 0xDEADBEEF, mask 0x0F, both held valid -> cycle 0 mem_wen=1, mask 0x0F, lsu_req_ready=1, ifu_req_ready=0; cycle 1 lsu_resp_valid=1, data=0; cycle 2 IFU granted with mem_ren=1.
- LSU read 0x80002000, mem_rvalid never asserted, TIMEOUT=16 -> lsu_resp_valid=1, err=1, data=0 exactly 16 cycles after issue; next LSU request accepted on the following cycle.
- LSU read issued, reset pulsed 1 cycle in WAIT_RD, then mem_rvalid=1 arrives -> no resp_valid on either side; state IDLE; a new IFU read issues normally.
- Both requesters valid continuously for 4 grants -> with MEM_ARB_RR_EN the grant order is LSU, IFU, LSU, IFU; without it, LSU, LSU, LSU, LSU.
- Back-to-back IFU reads 0x80000000, 0x80000008 with 1-cycle memory -> mem_ren at cycles 0 and 2; responses at cycles 1 and 3 carry the matching data.
